// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, ALU select, compare codes and sequencer states for calc_ctrl.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_AND = 4'hC;
    localparam logic [3:0] KEY_OR  = 4'hD;
    localparam logic [3:0] KEY_CMP = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam logic [3:0] ALU_IDLE = 4'h0;

    localparam logic [7:0] CMP_EQ = 8'h00;
    localparam logic [7:0] CMP_LT = 8'h01;
    localparam logic [7:0] CMP_GT = 8'h02;

    typedef enum logic [1:0] {
        ST_ENTRY_A = 2'd0,
        ST_ENTRY_B = 2'd1,
        ST_EXEC    = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

endpackage

// File: rtl/calc_digit_acc.sv
// rtl/calc_digit_acc.sv - combinational decimal entry step: cur*10 + digit with 8-bit overflow flag.
module calc_digit_acc (
    input  logic [7:0] cur,
    input  logic [3:0] digit,
    output logic [7:0] acc_next,
    output logic       ovf
);

    logic [11:0] wide;

    // 255*10 + 9 = 2559 fits in 12 bits, so the upper nibble is an exact overflow test.
    assign wide     = ({4'd0, cur} * 12'd10) + {8'd0, digit};
    assign acc_next = wide[7:0];
    assign ovf      = |wide[11:8];

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - keypad sequencer driving the 8-bit calculator ALU; CALC_CHAIN_EN lets an operator in SHOW chain the result.
module calc_ctrl
    import calc_pkg::*;
(
    input  logic       IN_clk,
    input  logic       IN_rst_n,
    input  logic       IN_key_valid,
    input  logic [3:0] IN_key_code,
    output logic [3:0] OUT_alu_cs,
    output logic [7:0] OUT_alu_a,
    output logic [7:0] OUT_alu_b,
    output logic       OUT_alu_carry_in,
    input  logic [7:0] IN_alu_s,
    input  logic       IN_alu_zero,
    input  logic       IN_alu_carry_out,
    output logic [7:0] OUT_display,
    output logic       OUT_neg,
    output logic       OUT_busy,
    output logic       OUT_err
);

    state_t     state, state_n;
    logic [7:0] a, b, result;
    logic [3:0] op;
    logic       neg, err, b_entered;

    logic       take, is_digit, is_op, is_eq;
    logic [7:0] acc_cur, acc_next;
    logic       acc_ovf;

    assign take     = IN_key_valid && (state != ST_EXEC);
    assign is_digit = (IN_key_code <= 4'd9);
    assign is_eq    = (IN_key_code == KEY_EQ);
    assign is_op    = !is_digit && !is_eq;

    assign acc_cur = (state == ST_ENTRY_B) ? b : a;

    calc_digit_acc u_acc (
        .cur      (acc_cur),
        .digit    (IN_key_code),
        .acc_next (acc_next),
        .ovf      (acc_ovf)
    );

    always_ff @(posedge IN_clk) begin
        if (!IN_rst_n) begin
            state <= ST_ENTRY_A;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        OUT_alu_cs  = ALU_IDLE;
        OUT_busy    = 1'b0;
        OUT_neg     = 1'b0;
        OUT_display = a;
        case (state)
            ST_ENTRY_A: begin
                if (take && is_op) state_n = ST_ENTRY_B;
            end
            ST_ENTRY_B: begin
                OUT_display = b_entered ? b : a;
                if (take && is_eq) state_n = ST_EXEC;
            end
            ST_EXEC: begin
                // Registers are frozen here, so the ENTRY_B view is the previous display.
                OUT_display = b_entered ? b : a;
                OUT_alu_cs  = op;
                OUT_busy    = 1'b1;
                state_n     = ST_SHOW;
            end
            ST_SHOW: begin
                OUT_display = result;
                OUT_neg     = neg;
                if (take && is_digit) state_n = ST_ENTRY_A;
`ifdef CALC_CHAIN_EN
                if (take && is_op) state_n = ST_ENTRY_B;
`endif
            end
            default: state_n = ST_ENTRY_A;
        endcase
    end

    always_ff @(posedge IN_clk) begin
        if (!IN_rst_n) begin
            a         <= 8'd0;
            b         <= 8'd0;
            op        <= ALU_IDLE;
            result    <= 8'd0;
            neg       <= 1'b0;
            err       <= 1'b0;
            b_entered <= 1'b0;
        end else begin
            case (state)
                ST_ENTRY_A: begin
                    if (take && is_digit) begin
                        if (acc_ovf) err <= 1'b1;
                        else         a   <= acc_next;
                    end else if (take && is_op) begin
                        op        <= IN_key_code;
                        b         <= 8'd0;
                        b_entered <= 1'b0;
                    end
                end
                ST_ENTRY_B: begin
                    if (take && is_digit) begin
                        if (acc_ovf) begin
                            err <= 1'b1;
                        end else begin
                            b         <= acc_next;
                            b_entered <= 1'b1;
                        end
                    end else if (take && is_op && !b_entered) begin
                        op <= IN_key_code;
                    end
                end
                ST_EXEC: begin
                    result <= IN_alu_s;
                    neg    <= 1'b0;
                    case (op)
                        KEY_SUB: neg <= IN_alu_carry_out;
                        KEY_ADD: if (IN_alu_carry_out) err <= 1'b1;
                        KEY_CMP: begin
                            if (IN_alu_zero && (IN_alu_s == 8'h00)) result <= CMP_EQ;
                            else if (IN_alu_carry_out)              result <= CMP_LT;
                            else                                    result <= CMP_GT;
                        end
                        default: ;
                    endcase
                end
                ST_SHOW: begin
                    if (take && is_digit) begin
                        a         <= {4'd0, IN_key_code};
                        b         <= 8'd0;
                        neg       <= 1'b0;
                        err       <= 1'b0;
                        b_entered <= 1'b0;
                    end
`ifdef CALC_CHAIN_EN
                    else if (take && is_op) begin
                        // Negative subtract results chain as their magnitude.
                        a         <= result;
                        b         <= 8'd0;
                        neg       <= 1'b0;
                        b_entered <= 1'b0;
                        op        <= IN_key_code;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign OUT_alu_a        = a;
    assign OUT_alu_b        = b;
    assign OUT_alu_carry_in = 1'b0;
    assign OUT_err          = err;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - directed self-checking bench for calc_ctrl with a behavioural ALU model.
module tb_calc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] alu_cs;
    logic [7:0] alu_a, alu_b, alu_s, display;
    logic       alu_carry_in, alu_zero, alu_carry_out;
    logic       neg, busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    calc_ctrl dut (
        .IN_clk           (clk),
        .IN_rst_n         (rst_n),
        .IN_key_valid     (key_valid),
        .IN_key_code      (key_code),
        .OUT_alu_cs       (alu_cs),
        .OUT_alu_a        (alu_a),
        .OUT_alu_b        (alu_b),
        .OUT_alu_carry_in (alu_carry_in),
        .IN_alu_s         (alu_s),
        .IN_alu_zero      (alu_zero),
        .IN_alu_carry_out (alu_carry_out),
        .OUT_display      (display),
        .OUT_neg          (neg),
        .OUT_busy         (busy),
        .OUT_err          (err)
    );

    // ALU: subtract returns magnitude with borrow; compare reports A-B zero and A<B.
    always_comb begin
        logic [8:0] sum;
        sum           = {1'b0, alu_a} + {1'b0, alu_b};
        alu_s         = 8'h00;
        alu_carry_out = 1'b0;
        case (alu_cs)
            4'hA: begin alu_s = sum[7:0]; alu_carry_out = sum[8]; end
            4'hB: begin
                alu_carry_out = (alu_a < alu_b);
                alu_s = (alu_a < alu_b) ? (alu_b - alu_a) : (alu_a - alu_b);
            end
            4'hC: alu_s = alu_a & alu_b;
            4'hD: alu_s = alu_a | alu_b;
            4'hE: begin alu_s = alu_a - alu_b; alu_carry_out = (alu_a < alu_b); end
            default: ;
        endcase
        alu_zero = (alu_s == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic keys(input string seq);
        for (int i = 0; i < seq.len(); i++) begin
            byte c;
            c = seq[i];
            if (c >= "0" && c <= "9") press(4'(c - "0"));
            else                      press(4'(c - "A" + 10));
        end
    endtask

    // Ends on the negedge after '=' has executed (display valid in SHOW).
    task automatic calc(input string seq, input string tag, input logic [7:0] exp_disp, input logic exp_neg);
        keys(seq);
        check({tag, "_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_disp"}, display, exp_disp);
        check({tag, "_neg"}, neg, exp_neg);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_disp", display, 8'h00);
        check("rst_cs", alu_cs, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_neg", neg, 1'b0);
        check("rst_a", alu_a, 8'h00);
        check("rst_b", alu_b, 8'h00);
        check("carry_in", alu_carry_in, 1'b0);

        keys("12");
        check("a_12", display, 8'd12);
        keys("A");
        check("op_shows_a", display, 8'd12);
        check("idle_cs", alu_cs, 4'h0);
        keys("3");
        check("b_3", display, 8'd3);
        keys("4");
        check("b_34", display, 8'd34);
        keys("F");
        check("exec_cs", alu_cs, 4'hA);
        check("exec_prev_disp", display, 8'd34);
        check("exec_busy", busy, 1'b1);
        @(negedge clk);
        check("add_disp", display, 8'h2E);
        check("add_busy_off", busy, 1'b0);
        check("add_neg", neg, 1'b0);
        check("add_err", err, 1'b0);
        check("show_cs", alu_cs, 4'h0);
        keys("F");
        check("show_eq_ignored", busy, 1'b0);

        do_reset();
        calc("5B9F", "sub", 8'h04, 1'b1);
        keys("8");
        check("exit_show_disp", display, 8'd8);
        check("exit_show_neg", neg, 1'b0);

        do_reset();
        keys("256");
        check("ovf_a", display, 8'd25);
        check("ovf_err", err, 1'b1);
        calc("A1F", "ovf_add", 8'd26, 1'b0);
        check("ovf_err_sticky", err, 1'b1);
        keys("3");
        check("err_cleared", err, 1'b0);

        do_reset();
        keys("255");
        check("max_a", display, 8'd255);
        check("max_err", err, 1'b0);
        calc("A1F", "add_carry", 8'h00, 1'b0);
        check("add_carry_err", err, 1'b1);

        do_reset();
        calc("7E9F", "cmp_lt", 8'h01, 1'b0);
        do_reset();
        calc("9E7F", "cmp_gt", 8'h02, 1'b0);
        do_reset();
        calc("7E7F", "cmp_eq", 8'h00, 1'b0);
        do_reset();
        calc("12C10F", "and", 8'd8, 1'b0);
        do_reset();
        calc("12D3F", "or", 8'd15, 1'b0);

        do_reset();
        keys("007");
        check("lead_zero", display, 8'd7);
        keys("F");
        check("eq_in_a_ignored", busy, 1'b0);
        check("eq_in_a_disp", display, 8'd7);

        do_reset();
        calc("9AB3F", "op_replace", 8'd6, 1'b0);
        do_reset();
        calc("9B3AF", "op_after_b", 8'd6, 1'b0);
        do_reset();
        calc("AF", "empty_ab", 8'd0, 1'b0);

        do_reset();
        calc("3A4F", "chain1", 8'd7, 1'b0);
`ifdef CALC_CHAIN_EN
        calc("A5F", "chain2", 8'd12, 1'b0);
`else
        keys("A");
        check("nochain_op_disp", display, 8'd7);
        keys("5");
        check("nochain_digit", display, 8'd5);
        keys("F");
        check("nochain_eq_ignored", busy, 1'b0);
        check("nochain_disp", display, 8'd5);
`endif

        do_reset();
        keys("1A2F");
        check("drop_in_exec", busy, 1'b1);
        key_valid = 1'b1;
        key_code  = 4'h5;
        @(negedge clk);
        key_valid = 1'b0;
        check("drop_disp", display, 8'd3);
        check("drop_a", alu_a, 8'd1);
        check("drop_b", alu_b, 8'd2);

        do_reset();
        keys("1A2F");
        check("rst_exec_busy", busy, 1'b1);
        rst_n     = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'h5;
        @(negedge clk);
        key_valid = 1'b0;
        rst_n     = 1'b1;
        check("rexec_disp", display, 8'h00);
        check("rexec_busy", busy, 1'b0);
        check("rexec_cs", alu_cs, 4'h0);
        check("rexec_a", alu_a, 8'h00);
        check("rexec_b", alu_b, 8'h00);
        check("rexec_err", err, 1'b0);
        check("rexec_neg", neg, 1'b0);
        @(negedge clk);
        check("rexec_after_disp", display, 8'h00);
        check("rexec_after_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
